sc_mul_sched: RTL and testbench
===============================

SC_MUL_SCHED -- requirements
Module: sc_mul_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the operand width.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the requester count (minimum 2).
REQ-003 Parameter STREAM_LENGTH, default 16, SHALL set the multiplier bitstream evaluation cycles (minimum 2).
REQ-004 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  per-requester accept.
- req_a  in  NUM_REQ*DATA_WIDTH  operand a; slice i belongs to requester i.
- req_b  in  NUM_REQ*DATA_WIDTH  operand b; slice i belongs to requester i.
- mul_a  out  DATA_WIDTH  operand a to the shared SC multiplier.
- mul_b  out  DATA_WIDTH  operand b to the shared SC multiplier.
- mul_start  out  1  stream-generator restart pulse.
- mul_result  in  2*DATA_WIDTH  multiplier product.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NUM_REQ)  index of the served requester.
- rsp_data  out  2*DATA_WIDTH  product.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and RESP.
REQ-006 In IDLE, req_ready SHALL be asserted combinationally only for the grant index: the first index with req_valid high, searched cyclically starting after last_grant. In RUN and RESP, all req_ready bits SHALL be 0.
REQ-007 Accept SHALL occur when req_valid[g] and req_ready[g] are both high. On accept, the block SHALL latch req_a[g], req_b[g] and g, set last_grant to g, load the counter with STREAM_LENGTH-1, and enter RUN.
REQ-008 In RUN, mul_a and mul_b SHALL hold the latched operands; in all other states they SHALL hold their last value.
REQ-009 mul_start SHALL be high for exactly the first RUN cycle.
REQ-010 In RUN, the counter SHALL decrement every cycle. In the cycle the counter is 0, mul_result SHALL be registered into rsp_data, the latched id SHALL be registered into rsp_id, and the state SHALL move to RESP.
REQ-011 Latency: for an accept at cycle t, rsp_valid SHALL first be high in cycle t+STREAM_LENGTH+1.
REQ-012 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL remain stable until rsp_ready is high. On that handshake the state SHALL return to IDLE, and no request SHALL be accepted in the handshake cycle.
REQ-013 rsp_data SHALL be the full 2*DATA_WIDTH product, with no truncation.
REQ-014 The counter width SHALL be $clog2(STREAM_LENGTH).
REQ-015 Deassertion of req_valid, or changes to req_a or req_b, after accept SHALL have no effect on the operation in flight.

Reset
REQ-016 While rst is low, all outputs SHALL be forced to 0 asynchronously, the state SHALL be IDLE, the counter SHALL be 0, and last_grant SHALL be NUM_REQ-1, so that requester 0 has first priority.
REQ-017 If rst goes low mid-operation, the in-flight operation SHALL be discarded and no response SHALL be produced for it.

Configuration
REQ-018 With SC_MUL_SCHED_ZERO_SKIP_EN defined, an accept with a zero latched operand SHALL skip RUN, go directly to RESP with rsp_data 0, and leave mul_start low.
REQ-019 Without SC_MUL_SCHED_ZERO_SKIP_EN, zero-operand requests SHALL follow the normal RUN path.

Structure
REQ-020 The shared package sc_cgra_pkg SHALL hold the state enum and the defaults for DATA_WIDTH and STREAM_LENGTH.
REQ-021 Round-robin grant logic SHALL be implemented in one sub-module, sc_rr_arbiter, which takes req_valid and last_grant and returns a one-hot grant.

Verification (NUM_REQ=4, STREAM_LENGTH=16, multiplier stub returning a*b)
REQ-022 Single request: req0 with a=11 and b=12, accepted at cycle 0 -> mul_a=11 and mul_b=12 in cycles 1-16, mul_start high in cycle 1 only, rsp_valid in cycle 17 with rsp_id=0 and rsp_data=132.
REQ-023 Contention: all four requesters held valid -> service order 0,1,2,3. Afterwards only requesters 0 and 2 remain valid -> service order 0, then 2.
REQ-024 Backpressure: rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable throughout, all req_ready bits 0, IDLE reached only after the handshake.
REQ-025 Reset mid-operation: rst pulled low in RUN cycle 8 -> all outputs 0 immediately, no response. After rst is released, with req3 and req0 both valid -> req0 accepted first.
REQ-026 Zero skip: a=0, b=200 -> with the macro, rsp_valid in cycle 1 with rsp_data=0 and no mul_start pulse; without the macro, rsp_valid in cycle 17 with rsp_data=0.

Source files
------------

// File: rtl/sc_cgra_pkg.sv
// Shared types and defaults for the stochastic-computing multiplier scheduler.
package sc_cgra_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_STREAM_LENGTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/sc_rr_arbiter.sv
// Round-robin grant: first valid requester found cyclically after last_grant.
module sc_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_valid_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last_grant_i) + i) % N);
            if (!found && req_valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_mul_sched.sv
// Schedules requesters onto one shared SC multiplier; optional zero-operand
// bypass enabled by SC_MUL_SCHED_ZERO_SKIP_EN.
module sc_mul_sched
    import sc_cgra_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_REQ       = 4,
    parameter int STREAM_LENGTH = DEF_STREAM_LENGTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic [DATA_WIDTH-1:0]           mul_a,
    output logic [DATA_WIDTH-1:0]           mul_b,
    output logic                            mul_start,
    input  logic [2*DATA_WIDTH-1:0]         mul_result,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [2*DATA_WIDTH-1:0]         rsp_data,
    output logic                            busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(STREAM_LENGTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STREAM_LENGTH - 1);

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           last_q;
    logic [IW-1:0]           id_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic                    start_q;
    logic                    rsp_valid_q;
    logic [IW-1:0]           rsp_id_q;
    logic [2*DATA_WIDTH-1:0] rsp_data_q;

    logic [NUM_REQ-1:0]      gnt;
    logic [IW-1:0]           gidx;
    logic [DATA_WIDTH-1:0]   a_sel;
    logic [DATA_WIDTH-1:0]   b_sel;
    logic                    accept;

    sc_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_valid_i  (req_valid),
        .last_grant_i (last_q),
        .grant_o      (gnt)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        gidx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_sel = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                gidx  = IW'(i);
            end
        end
    end

    // Ready is gated by rst so it reads 0 while reset is held.
    assign req_ready = gnt & {NUM_REQ{rst && (state_q == IDLE)}};
    assign accept    = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= IW'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q    <= a_sel;
                        b_q    <= b_sel;
                        id_q   <= gidx;
                        last_q <= gidx;
                        cnt_q  <= CNT_LOAD;
`ifdef SC_MUL_SCHED_ZERO_SKIP_EN
                        if (a_sel == '0 || b_sel == '0) begin
                            rsp_data_q  <= '0;
                            rsp_id_q    <= gidx;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= RUN;
                        end
`else
                        start_q <= 1'b1;
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        rsp_data_q  <= mul_result;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_start = start_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sc_mul_sched.sv
// Directed bench for sc_mul_sched with a combinational a*b multiplier stub.
module tb_sc_mul_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_start;
    logic [15:0] mul_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int lat;

    sc_mul_sched #(
        .DATA_WIDTH    (8),
        .NUM_REQ       (4),
        .STREAM_LENGTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    assign mul_result = {8'd0, mul_a} * {8'd0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Waits for rsp_valid; lat counts cycles stepped (bounded).
    task automatic wait_rsp(inout int n);
        while (!rsp_valid && n < 60) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        step();
        #1;
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_rsp_data", rsp_data, 0);
        step();

        // Single request on requester 0
        rst       = 1'b1;
        req_valid = 4'b0001;
        req_a     = {8'd0, 8'd0, 8'd0, 8'd11};
        req_b     = {8'd0, 8'd0, 8'd0, 8'd12};
        #1;
        chk("single_ready", req_ready, 4'b0001);
        step();
        chk("single_start_c1", mul_start, 1);
        chk("single_a_c1", mul_a, 11);
        chk("single_b_c1", mul_b, 12);
        chk("single_busy_c1", busy, 1);
        req_valid = 4'b0000;
        req_a     = {8'd9, 8'd9, 8'd9, 8'd99};
        req_b     = {8'd9, 8'd9, 8'd9, 8'd98};
        #1;
        chk("single_ready_run", req_ready, 4'h0);
        for (int c = 2; c <= 16; c++) begin
            step();
            chk("single_start_run", mul_start, 0);
            chk("single_a_run", mul_a, 11);
            chk("single_b_run", mul_b, 12);
            chk("single_rsp_early", rsp_valid, 0);
        end
        step();
        chk("single_rsp_valid_c17", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_data", rsp_data, 132);
        step();
        chk("single_idle_busy", busy, 0);
        chk("single_idle_valid", rsp_valid, 0);

        // Zero operand on requester 1
        req_a     = {8'd0, 8'd0, 8'd0, 8'd0};
        req_b     = {8'd0, 8'd0, 8'd200, 8'd0};
        req_valid = 4'b0010;
        #1;
        chk("zero_ready", req_ready, 4'b0010);
        step();
        req_valid = 4'b0000;
`ifdef SC_MUL_SCHED_ZERO_SKIP_EN
        chk("zero_start", mul_start, 0);
        chk("zero_rsp_valid_c1", rsp_valid, 1);
        chk("zero_rsp_data", rsp_data, 0);
        chk("zero_rsp_id", rsp_id, 1);
`else
        chk("zero_start", mul_start, 1);
        lat = 1;
        wait_rsp(lat);
        chk("zero_latency", lat, 17);
        chk("zero_rsp_data", rsp_data, 0);
        chk("zero_rsp_id", rsp_id, 1);
`endif
        step();

        // Contention from fresh reset
        rst = 1'b0;
        step();
        rst       = 1'b1;
        req_a     = {8'd6, 8'd5, 8'd4, 8'd3};
        req_b     = {8'd23, 8'd22, 8'd21, 8'd20};
        req_valid = 4'hF;
        lat = 0;
        wait_rsp(lat);
        chk("cont0_id", rsp_id, 0);
        chk("cont0_data", rsp_data, 60);
        chk("cont0_ready_hs", req_ready, 4'h0);
        step();
        lat = 0;
        wait_rsp(lat);
        chk("cont1_id", rsp_id, 1);
        chk("cont1_data", rsp_data, 84);
        step();
        lat = 0;
        wait_rsp(lat);
        chk("cont2_id", rsp_id, 2);
        chk("cont2_data", rsp_data, 110);
        step();
        lat = 0;
        wait_rsp(lat);
        chk("cont3_id", rsp_id, 3);
        chk("cont3_data", rsp_data, 138);
        req_valid = 4'b0101;
        step();
        lat = 0;
        wait_rsp(lat);
        chk("pair0_id", rsp_id, 0);
        chk("pair0_data", rsp_data, 60);
        step();
        lat = 0;
        wait_rsp(lat);
        chk("pair2_id", rsp_id, 2);
        chk("pair2_data", rsp_data, 110);
        req_valid = 4'b0000;
        step();

        // Backpressure on requester 1 (4*21)
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        lat = 0;
        wait_rsp(lat);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 84);
            chk("bp_id", rsp_id, 1);
            chk("bp_ready", req_ready, 4'h0);
            chk("bp_busy", busy, 1);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        #1;
        chk("bp_hs_valid", rsp_valid, 1);
        step();
        chk("bp_after_busy", busy, 0);
        chk("bp_after_valid", rsp_valid, 0);

        // Reset in RUN cycle 8
        req_a     = {8'd0, 8'd0, 8'd0, 8'd11};
        req_b     = {8'd0, 8'd0, 8'd0, 8'd12};
        req_valid = 4'b0001;
        #1;
        chk("mid_ready", req_ready, 4'b0001);
        step();
        req_valid = 4'b0000;
        for (int c = 2; c <= 8; c++) step();
        chk("mid_busy_c8", busy, 1);
        req_valid = 4'b0001;
        rst       = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mul_a", mul_a, 0);
        chk("mid_rst_mul_b", mul_b, 0);
        chk("mid_rst_start", mul_start, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_id", rsp_id, 0);
        chk("mid_rst_ready", req_ready, 4'h0);
        req_valid = 4'b0000;
        step();
        step();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("mid_no_rsp", rsp_valid, 0);
        end
        req_valid = 4'b1001;
        #1;
        chk("post_rst_ready", req_ready, 4'b0001);
        step();
        req_valid = 4'b0000;
        lat = 1;
        wait_rsp(lat);
        chk("post_rst_latency", lat, 17);
        chk("post_rst_id", rsp_id, 0);
        chk("post_rst_data", rsp_data, 132);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
